// File: rtl/tile_feeder_pkg.sv
// ============================================================================
//  Module      : tile_feeder_pkg
//  Description : Shared types and constants for the tile operand feeder.
//                Holds the feeder FSM state encoding, the slot count and a
//                row-packing helper for the row-wide read words.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tile_feeder_pkg;

    // Number of array slots (tile pairs) assembled per group
    localparam int SLOTS      = 4;
    localparam int SLOT_WIDTH = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        DRAIN = 3'd2,
        ISSUE = 3'd3,
        DONE  = 3'd4
    } feeder_state_e;

    // Bit offset of element elem_idx inside a packed read row
    function automatic int elem_lsb(input int elem_idx, input int elem_width);
        return elem_idx * elem_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_feeder_addr_gen.sv
// ============================================================================
//  Module      : tile_feeder_addr_gen
//  Description : Row/slot/group counters and read-address arithmetic for the
//                tile operand feeder. Addresses advance one row per issued
//                read; the running row offset wraps modulo 2^ADDR_WIDTH.
//                single_slot (latched at start) restricts each group to
//                slot 0 for the broadcast load pattern.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_feeder_addr_gen
    import tile_feeder_pkg::*;
#(
    parameter  int TILE_SIZE  = 4,
    parameter  int ADDR_WIDTH = 12,
    parameter  int CNT_WIDTH  = 8,
    localparam int ROW_WIDTH  = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [CNT_WIDTH-1:0]  num_grp,
    input  logic                  single_slot,
    input  logic                  advance,
    input  logic                  grp_step,
    output logic [ADDR_WIDTH-1:0] rd_a_addr,
    output logic [ADDR_WIDTH-1:0] rd_b_addr,
    output logic [ROW_WIDTH-1:0]  row,
    output logic [SLOT_WIDTH-1:0] slot,
    output logic                  last_read,
    output logic                  last_grp
);

    localparam logic [ROW_WIDTH-1:0]  C_ROW_LAST  = ROW_WIDTH'(TILE_SIZE - 1);
    localparam logic [SLOT_WIDTH-1:0] C_SLOT_LAST = SLOT_WIDTH'(SLOTS - 1);

    logic [ADDR_WIDTH-1:0] r_a_base;
    logic [ADDR_WIDTH-1:0] r_b_base;
    logic [CNT_WIDTH-1:0]  r_num_grp;
    logic                  r_single;
    logic [ADDR_WIDTH-1:0] r_offset;
    logic [ROW_WIDTH-1:0]  r_row;
    logic [SLOT_WIDTH-1:0] r_slot;
    logic [CNT_WIDTH-1:0]  r_grp;

    logic w_row_last;
    logic w_slot_last;

    assign w_row_last  = (r_row == C_ROW_LAST);
    assign w_slot_last = r_single ? (r_slot == '0) : (r_slot == C_SLOT_LAST);

    // The row offset (g*SLOTS+s)*TILE_SIZE+r (or g*TILE_SIZE+r in single-slot
    // mode) is simply the number of reads issued so far, so a running counter
    // replaces the multiply.
    assign rd_a_addr = r_a_base + r_offset;
    assign rd_b_addr = r_b_base + r_offset;
    assign row       = r_row;
    assign slot      = r_slot;
    assign last_read = w_row_last && w_slot_last;
    assign last_grp  = (r_grp == (r_num_grp - CNT_WIDTH'(1)));

    // Latch command fields at start, then step row (fastest), slot and group
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_base  <= '0;
            r_b_base  <= '0;
            r_num_grp <= '0;
            r_single  <= 1'b0;
            r_offset  <= '0;
            r_row     <= '0;
            r_slot    <= '0;
            r_grp     <= '0;
        end else if (start) begin
            r_a_base  <= a_base;
            r_b_base  <= b_base;
            r_num_grp <= num_grp;
            r_single  <= single_slot;
            r_offset  <= '0;
            r_row     <= '0;
            r_slot    <= '0;
            r_grp     <= '0;
        end else begin
            if (advance) begin
                r_offset <= r_offset + ADDR_WIDTH'(1);
                if (w_row_last) begin
                    r_row  <= '0;
                    r_slot <= w_slot_last ? '0 : (r_slot + SLOT_WIDTH'(1));
                end else begin
                    r_row  <= r_row + ROW_WIDTH'(1);
                end
            end
            if (grp_step) begin
                r_grp <= r_grp + CNT_WIDTH'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/tile_operand_feeder.sv
// ============================================================================
//  Module      : tile_operand_feeder
//  Description : Fetches A/B operand rows from two row-wide read ports,
//                assembles four TILE_SIZE x TILE_SIZE tile pairs and issues
//                each group to the 4-array MAC pipeline as a one-cycle
//                valid pulse, flagging the group that closes a reduction.
//                Optional feature macro: TILE_FEEDER_BCAST_EN (cmd_bcast
//                loads only slot 0 and drives it on all four outputs).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tile_operand_feeder
    import tile_feeder_pkg::*;
#(
    parameter int TILE_SIZE  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic [1:0]                      cmd_mode,
    input  logic [ADDR_WIDTH-1:0]           cmd_a_base,
    input  logic [ADDR_WIDTH-1:0]           cmd_b_base,
    input  logic [CNT_WIDTH-1:0]            cmd_num_grp,
    input  logic                            cmd_bcast,
    output logic                            rd_en,
    output logic [ADDR_WIDTH-1:0]           rd_a_addr,
    output logic [ADDR_WIDTH-1:0]           rd_b_addr,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] rd_a_data,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] rd_b_data,
    output logic [1:0]                      mode_out,
    output logic                            valid_out,
    output logic                            grp_last,
    output logic [DATA_WIDTH-1:0]           A0_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           A1_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           A2_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           A3_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           B0_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           B1_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           B2_mat [TILE_SIZE][TILE_SIZE],
    output logic [DATA_WIDTH-1:0]           B3_mat [TILE_SIZE][TILE_SIZE],
    output logic                            cmd_done
);

    localparam int ROW_WIDTH = (TILE_SIZE > 1) ? $clog2(TILE_SIZE) : 1;

    feeder_state_e r_state;
    feeder_state_e w_state_next;

    logic                  w_accept;
    logic                  w_last_read;
    logic                  w_last_grp;
    logic                  w_bcast_req;
    logic                  r_bcast;
    logic [1:0]            r_mode;
    logic [ROW_WIDTH-1:0]  w_row;
    logic [SLOT_WIDTH-1:0] w_slot;
    logic                  r_cap_valid;
    logic [ROW_WIDTH-1:0]  r_cap_row;
    logic [SLOT_WIDTH-1:0] r_cap_slot;

    logic [DATA_WIDTH-1:0] r_a_tile [SLOTS][TILE_SIZE][TILE_SIZE];
    logic [DATA_WIDTH-1:0] r_b_tile [SLOTS][TILE_SIZE][TILE_SIZE];

`ifdef TILE_FEEDER_BCAST_EN
    assign w_bcast_req = cmd_bcast;
`else
    // Broadcast disabled: the request pin is accepted but has no effect
    logic w_unused_bcast;
    assign w_bcast_req    = 1'b0;
    assign w_unused_bcast = cmd_bcast;
`endif

    assign w_accept = cmd_valid && cmd_ready;
    assign mode_out = r_mode;

    tile_feeder_addr_gen #(
        .TILE_SIZE  (TILE_SIZE),
        .ADDR_WIDTH (ADDR_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_addr_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (w_accept),
        .a_base      (cmd_a_base),
        .b_base      (cmd_b_base),
        .num_grp     (cmd_num_grp),
        .single_slot (w_bcast_req),
        .advance     (rd_en),
        .grp_step    (valid_out),
        .rd_a_addr   (rd_a_addr),
        .rd_b_addr   (rd_b_addr),
        .row         (w_row),
        .slot        (w_slot),
        .last_read   (w_last_read),
        .last_grp    (w_last_grp)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and strobe decode; DRAIN exists only to capture the row
    // returned for the final read before the group is issued
    always_comb begin
        w_state_next = r_state;
        cmd_ready    = 1'b0;
        rd_en        = 1'b0;
        valid_out    = 1'b0;
        grp_last     = 1'b0;
        cmd_done     = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_state_next = (cmd_num_grp == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                rd_en = 1'b1;
                if (w_last_read) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_state_next = ISSUE;
            end
            ISSUE: begin
                valid_out    = 1'b1;
                grp_last     = w_last_grp;
                w_state_next = w_last_grp ? DONE : LOAD;
            end
            DONE: begin
                cmd_done     = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Command attributes held from accept until the next accept
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mode  <= 2'b00;
            r_bcast <= 1'b0;
        end else if (w_accept) begin
            r_mode  <= cmd_mode;
            r_bcast <= w_bcast_req;
        end
    end

    // Delay the row/slot tag of each read to line up with its returned data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cap_valid <= 1'b0;
            r_cap_row   <= '0;
            r_cap_slot  <= '0;
        end else begin
            r_cap_valid <= rd_en;
            r_cap_row   <= w_row;
            r_cap_slot  <= w_slot;
        end
    end

    // Unpack returned rows into the tile storage of the tagged slot/row
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SLOTS; s++) begin
                for (int r = 0; r < TILE_SIZE; r++) begin
                    for (int j = 0; j < TILE_SIZE; j++) begin
                        r_a_tile[s][r][j] <= '0;
                        r_b_tile[s][r][j] <= '0;
                    end
                end
            end
        end else if (r_cap_valid) begin
            for (int j = 0; j < TILE_SIZE; j++) begin
                r_a_tile[r_cap_slot][r_cap_row][j] <= rd_a_data[elem_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
                r_b_tile[r_cap_slot][r_cap_row][j] <= rd_b_data[elem_lsb(j, DATA_WIDTH) +: DATA_WIDTH];
            end
        end
    end

    // Drive the array inputs; in broadcast mode every array sees slot 0
    always_comb begin
        for (int r = 0; r < TILE_SIZE; r++) begin
            for (int j = 0; j < TILE_SIZE; j++) begin
                A0_mat[r][j] = r_a_tile[0][r][j];
                B0_mat[r][j] = r_b_tile[0][r][j];
                A1_mat[r][j] = r_bcast ? r_a_tile[0][r][j] : r_a_tile[1][r][j];
                B1_mat[r][j] = r_bcast ? r_b_tile[0][r][j] : r_b_tile[1][r][j];
                A2_mat[r][j] = r_bcast ? r_a_tile[0][r][j] : r_a_tile[2][r][j];
                B2_mat[r][j] = r_bcast ? r_b_tile[0][r][j] : r_b_tile[2][r][j];
                A3_mat[r][j] = r_bcast ? r_a_tile[0][r][j] : r_a_tile[3][r][j];
                B3_mat[r][j] = r_bcast ? r_b_tile[0][r][j] : r_b_tile[3][r][j];
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_tile_operand_feeder.sv
// ============================================================================
//  Module      : tb_tile_operand_feeder
//  Description : Scoreboard bench for tile_operand_feeder. A row memory model
//                answers reads; every accepted command pushes its expected
//                reads, issues and completion onto queues that are popped as
//                the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tile_operand_feeder;

    localparam int T  = 4;
    localparam int DW = 16;
    localparam int AW = 12;
    localparam int CW = 8;
    localparam int TB = T * T * DW;

    typedef logic [511:0] val_t;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [AW-1:0] b;
    } addr_t;

    typedef struct packed {
        int               cyc;
        logic             last;
        logic [1:0]       mode;
        logic [3:0][TB-1:0] a;
        logic [3:0][TB-1:0] b;
    } issue_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [1:0]      cmd_mode = 2'b00;
    logic [AW-1:0]   cmd_a_base = '0;
    logic [AW-1:0]   cmd_b_base = '0;
    logic [CW-1:0]   cmd_num_grp = '0;
    logic            cmd_bcast = 1'b0;
    logic            rd_en;
    logic [AW-1:0]   rd_a_addr, rd_b_addr;
    logic [T*DW-1:0] rd_a_data = '0;
    logic [T*DW-1:0] rd_b_data = '0;
    logic [1:0]      mode_out;
    logic            valid_out, grp_last, cmd_done;
    logic [DW-1:0]   A0_mat [T][T], A1_mat [T][T], A2_mat [T][T], A3_mat [T][T];
    logic [DW-1:0]   B0_mat [T][T], B1_mat [T][T], B2_mat [T][T], B3_mat [T][T];

    int     checks = 0;
    int     failures = 0;
    int     cyc = 0;
    int     done_cyc = -1;
    bit     mon_en = 1'b0;
    addr_t  addr_q [$];
    issue_t issue_q [$];
    int     done_q [$];

    tile_operand_feeder #(
        .TILE_SIZE (T), .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .CNT_WIDTH (CW)
    ) dut (
        .clk (clk), .rst_n (rst_n),
        .cmd_valid (cmd_valid), .cmd_ready (cmd_ready), .cmd_mode (cmd_mode),
        .cmd_a_base (cmd_a_base), .cmd_b_base (cmd_b_base),
        .cmd_num_grp (cmd_num_grp), .cmd_bcast (cmd_bcast),
        .rd_en (rd_en), .rd_a_addr (rd_a_addr), .rd_b_addr (rd_b_addr),
        .rd_a_data (rd_a_data), .rd_b_data (rd_b_data),
        .mode_out (mode_out), .valid_out (valid_out), .grp_last (grp_last),
        .A0_mat (A0_mat), .A1_mat (A1_mat), .A2_mat (A2_mat), .A3_mat (A3_mat),
        .B0_mat (B0_mat), .B1_mat (B1_mat), .B2_mat (B2_mat), .B3_mat (B3_mat),
        .cmd_done (cmd_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input val_t obs, input val_t exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Memory contents: element = {row address, element index, port tag}
    function automatic logic [DW-1:0] elem(input logic [AW-1:0] ad, input int j, input bit isb);
        logic [1:0] jj;
        jj = 2'(j);
        return {ad, jj, isb ? 2'b10 : 2'b01};
    endfunction

    function automatic logic [T*DW-1:0] mem_row(input logic [AW-1:0] ad, input bit isb);
        logic [T*DW-1:0] v;
        for (int j = 0; j < T; j++) v[j*DW +: DW] = elem(ad, j, isb);
        return v;
    endfunction

    function automatic logic [TB-1:0] exp_tile(input logic [AW-1:0] base, input int off, input bit isb);
        logic [TB-1:0] v;
        logic [AW-1:0] ad;
        for (int r = 0; r < T; r++) begin
            ad = base + AW'(off + r);
            for (int j = 0; j < T; j++) v[(r*T+j)*DW +: DW] = elem(ad, j, isb);
        end
        return v;
    endfunction

    function automatic logic [TB-1:0] pack_tile(input logic [DW-1:0] m [T][T]);
        logic [TB-1:0] v;
        for (int r = 0; r < T; r++)
            for (int j = 0; j < T; j++) v[(r*T+j)*DW +: DW] = m[r][j];
        return v;
    endfunction

    // Read ports: data valid one cycle after rd_en
    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= mem_row(rd_a_addr, 1'b0);
            rd_b_data <= mem_row(rd_b_addr, 1'b1);
        end
    end

    // Build the expected reads, issues and completion for the accepted command
    task automatic push_cmd();
        int     tacc, per, nslot, n, off;
        bit     bc;
        issue_t e;
        addr_t  ad;
        tacc = cyc;
`ifdef TILE_FEEDER_BCAST_EN
        bc = cmd_bcast;
`else
        bc = 1'b0;
`endif
        per   = bc ? 6 : 18;
        nslot = bc ? 1 : 4;
        n     = int'(cmd_num_grp);
        for (int g = 0; g < n; g++) begin
            for (int s = 0; s < nslot; s++) begin
                for (int r = 0; r < T; r++) begin
                    off  = (g * nslot + s) * T + r;
                    ad.a = cmd_a_base + AW'(off);
                    ad.b = cmd_b_base + AW'(off);
                    addr_q.push_back(ad);
                end
            end
            e.cyc  = tacc + per * (g + 1);
            e.last = (g == n - 1);
            e.mode = cmd_mode;
            for (int k = 0; k < 4; k++) begin
                off    = (g * nslot + (bc ? 0 : k)) * T;
                e.a[k] = exp_tile(cmd_a_base, off, 1'b0);
                e.b[k] = exp_tile(cmd_b_base, off, 1'b1);
            end
            issue_q.push_back(e);
        end
        done_cyc = tacc + per * n + 1;
        done_q.push_back(done_cyc);
    endtask

    // Monitor: sample away from the active edge and pop the scoreboard
    always @(negedge clk) begin
        addr_t  ea;
        issue_t ei;
        int     ed;
        if (mon_en && rst_n) begin
            check("cmd_ready", val_t'(cmd_ready), val_t'(cyc > done_cyc));
            if (rd_en) begin
                if (addr_q.size() == 0) check("rd_en_unexpected", val_t'(1), val_t'(0));
                else begin
                    ea = addr_q.pop_front();
                    check("rd_a_addr", val_t'(rd_a_addr), val_t'(ea.a));
                    check("rd_b_addr", val_t'(rd_b_addr), val_t'(ea.b));
                end
            end
            if (valid_out) begin
                if (issue_q.size() == 0) check("valid_unexpected", val_t'(1), val_t'(0));
                else begin
                    ei = issue_q.pop_front();
                    check("issue_cycle", val_t'(cyc), val_t'(ei.cyc));
                    check("grp_last", val_t'(grp_last), val_t'(ei.last));
                    check("mode_out", val_t'(mode_out), val_t'(ei.mode));
                    check("A0_mat", val_t'(pack_tile(A0_mat)), val_t'(ei.a[0]));
                    check("A1_mat", val_t'(pack_tile(A1_mat)), val_t'(ei.a[1]));
                    check("A2_mat", val_t'(pack_tile(A2_mat)), val_t'(ei.a[2]));
                    check("A3_mat", val_t'(pack_tile(A3_mat)), val_t'(ei.a[3]));
                    check("B0_mat", val_t'(pack_tile(B0_mat)), val_t'(ei.b[0]));
                    check("B1_mat", val_t'(pack_tile(B1_mat)), val_t'(ei.b[1]));
                    check("B2_mat", val_t'(pack_tile(B2_mat)), val_t'(ei.b[2]));
                    check("B3_mat", val_t'(pack_tile(B3_mat)), val_t'(ei.b[3]));
                end
            end else if (grp_last) begin
                check("grp_last_stray", val_t'(1), val_t'(0));
            end
            if (cmd_done) begin
                if (done_q.size() == 0) check("done_unexpected", val_t'(1), val_t'(0));
                else begin
                    ed = done_q.pop_front();
                    check("done_cycle", val_t'(cyc), val_t'(ed));
                end
            end
            if (cmd_valid && cmd_ready) push_cmd();
        end
    end

    task automatic send_cmd(input logic [1:0] mode, input logic [AW-1:0] ab, input logic [AW-1:0] bb,
                            input int n, input bit bc);
        int i;
        i = 0;
        while (!cmd_ready && i < 200) begin
            @(posedge clk);
            i++;
        end
        check("ready_before_cmd", val_t'(cmd_ready), val_t'(1));
        @(posedge clk); #1;
        cmd_valid   = 1'b1;
        cmd_mode    = mode;
        cmd_a_base  = ab;
        cmd_b_base  = bb;
        cmd_num_grp = CW'(n);
        cmd_bcast   = bc;
        @(posedge clk); #1;
        cmd_valid   = 1'b0;
    endtask

    task automatic wait_complete();
        bit empty;
        empty = 1'b0;
        for (int i = 0; i < 2000 && !empty; i++) begin
            @(negedge clk);
            #1;
            empty = (addr_q.size() == 0) && (issue_q.size() == 0) && (done_q.size() == 0);
        end
        check("cmd_complete", val_t'(empty), val_t'(1));
        repeat (3) @(posedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", val_t'(cmd_ready), val_t'(1));
        check("rst_rd_en", val_t'(rd_en), val_t'(0));
        check("rst_valid_out", val_t'(valid_out), val_t'(0));
        check("rst_grp_last", val_t'(grp_last), val_t'(0));
        check("rst_cmd_done", val_t'(cmd_done), val_t'(0));
        check("rst_mode_out", val_t'(mode_out), val_t'(0));
        check("rst_rd_a_addr", val_t'(rd_a_addr), val_t'(0));
        check("rst_rd_b_addr", val_t'(rd_b_addr), val_t'(0));
        check("rst_A0_mat", val_t'(pack_tile(A0_mat)), val_t'(0));
        check("rst_B3_mat", val_t'(pack_tile(B3_mat)), val_t'(0));
        @(posedge clk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (50) @(posedge clk);

        // Single group, then three groups
        send_cmd(2'b01, 12'h010, 12'h200, 1, 1'b0);
        wait_complete();
        send_cmd(2'b00, 12'h123, 12'h456, 3, 1'b0);
        wait_complete();

        // Empty command and address wrap
        send_cmd(2'b10, 12'h300, 12'h400, 0, 1'b0);
        wait_complete();
        send_cmd(2'b11, 12'hFFC, 12'hFF0, 1, 1'b0);
        wait_complete();

        // Reset in the middle of a two-group command
        send_cmd(2'b01, 12'h080, 12'h0C0, 2, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        addr_q.delete();
        issue_q.delete();
        done_q.delete();
        done_cyc = -1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        send_cmd(2'b10, 12'h500, 12'h600, 2, 1'b0);
        wait_complete();

        // Broadcast request (ignored unless the feature is built in)
        send_cmd(2'b11, 12'h700, 12'h7A0, 2, 1'b1);
        wait_complete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
